// File: rtl/uart_pkg.sv
// Shared definitions for the UART-ALU system: sequencer state encoding,
// default data widths and the ALU opcode set.
package uart_pkg;

  localparam int NB_DATA_DEFAULT = 8;
  localparam int NB_OP_DEFAULT   = 6;
  localparam int NB_STATE        = 3;

  typedef enum logic [NB_STATE-1:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_t;

  localparam logic [NB_OP_DEFAULT-1:0] OP_ADD = 6'b100000;
  localparam logic [NB_OP_DEFAULT-1:0] OP_SUB = 6'b100010;
  localparam logic [NB_OP_DEFAULT-1:0] OP_AND = 6'b100100;
  localparam logic [NB_OP_DEFAULT-1:0] OP_OR  = 6'b100101;
  localparam logic [NB_OP_DEFAULT-1:0] OP_XOR = 6'b100110;
  localparam logic [NB_OP_DEFAULT-1:0] OP_SRA = 6'b000011;
  localparam logic [NB_OP_DEFAULT-1:0] OP_SRL = 6'b000010;
  localparam logic [NB_OP_DEFAULT-1:0] OP_NOR = 6'b100111;

  function automatic logic is_busy_state(input state_t s);
    return (s == EXEC) || (s == SEND) || (s == WAIT_TX);
  endfunction

endpackage

// File: rtl/inter_byte_timer.sv
// Counts baud ticks between bytes of one command and flags expiry when the
// count would reach TIMEOUT_TICKS; a clear in the same cycle suppresses expiry.
module inter_byte_timer #(
  parameter int TIMEOUT_TICKS = 1600
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_enable,
  input  logic i_clear,
  input  logic i_tick,
  output logic o_expire
);

  localparam int NB_COUNT = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [NB_COUNT-1:0] LAST_COUNT = NB_COUNT'(TIMEOUT_TICKS - 1);

  logic [NB_COUNT-1:0] count;

  assign o_expire = i_enable && i_tick && !i_clear && (count == LAST_COUNT);

  // Expiry resets the count, so it tops out at TIMEOUT_TICKS-1 and never wraps.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      count <= '0;
    end else if (!i_enable || i_clear || o_expire) begin
      count <= '0;
    end else if (i_tick) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_alu_interface.sv
// Sequencer between uart_rx, the ALU and uart_tx: gathers A, B and opcode,
// captures the ALU result and hands it to uart_tx, aborting stalled commands.
module uart_alu_interface
  import uart_pkg::*;
#(
  parameter int NB_DATA       = NB_DATA_DEFAULT,
  parameter int NB_OP         = NB_OP_DEFAULT,
  parameter int TIMEOUT_TICKS = 1600
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_op,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_busy,
  output logic               o_error,
  output logic               o_overrun
);

  state_t             state, state_next;
  logic [NB_DATA-1:0] data_a_next, data_b_next, tx_data_next;
  logic [NB_OP-1:0]   op_next;
  logic               error_next, overrun_next;
  logic               timer_enable, timer_expire;

  assign timer_enable = (state == WAIT_B) || (state == WAIT_OP);

  inter_byte_timer #(
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) u_timer (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_enable (timer_enable),
    .i_clear  (i_rx_done),
    .i_tick   (i_tick),
    .o_expire (timer_expire)
  );

  always_comb begin
    state_next   = state;
    data_a_next  = o_data_a;
    data_b_next  = o_data_b;
    op_next      = o_op;
    tx_data_next = o_tx_data;
    error_next   = 1'b0;
    overrun_next = 1'b0;
    case (state)
      WAIT_A: begin
        if (i_rx_done) begin
          data_a_next = i_rx_data;
          state_next  = WAIT_B;
        end
      end
      WAIT_B: begin
        if (i_rx_done) begin
          data_b_next = i_rx_data;
          state_next  = WAIT_OP;
        end else if (timer_expire) begin
          error_next = 1'b1;
          state_next = WAIT_A;
        end
      end
      WAIT_OP: begin
        if (i_rx_done) begin
          op_next    = i_rx_data[NB_OP-1:0];
          state_next = EXEC;
        end else if (timer_expire) begin
          error_next = 1'b1;
          state_next = WAIT_A;
        end
      end
      EXEC: begin
        tx_data_next = i_alu_result;
        overrun_next = i_rx_done;
        state_next   = SEND;
      end
      SEND: begin
        overrun_next = i_rx_done;
        state_next   = WAIT_TX;
      end
      WAIT_TX: begin
        overrun_next = i_rx_done;
        if (i_tx_done) begin
          state_next = WAIT_A;
        end
      end
      default: state_next = WAIT_A;
    endcase
  end

  // tx_start and busy follow the registered state so uart_tx sees the start
  // pulse in the same cycle the result byte becomes valid.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state      <= WAIT_A;
      o_data_a   <= '0;
      o_data_b   <= '0;
      o_op       <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
      o_error    <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      state      <= state_next;
      o_data_a   <= data_a_next;
      o_data_b   <= data_b_next;
      o_op       <= op_next;
      o_tx_data  <= tx_data_next;
      o_tx_start <= (state_next == SEND);
      o_busy     <= is_busy_state(state_next);
      o_error    <= error_next;
      o_overrun  <= overrun_next;
    end
  end

endmodule

// File: doc/uart_alu_interface.md
Name: uart_alu_interface

Overview:
- Sequencer between uart_rx, the ALU and uart_tx in the UART-ALU system.
- Collects three received bytes (operand A, operand B, opcode), presents them to the combinational ALU, and captures the result. It then starts one uart_tx transmission and waits for it to finish.
- Consumes the baud_rate_generator tick to abort a partially received command after an inter-byte timeout.

Parameters:
- NB_DATA, 8, width of UART data bytes, ALU operands and ALU result.
- NB_OP, 6, opcode width; taken from i_rx_data[NB_OP-1:0].
- TIMEOUT_TICKS, 1600, baud ticks allowed between bytes of one command (about 10 frames at 16x oversampling); must be ≥1.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  synchronous, active-low reset.
- i_tick  in  1  baud tick from baud_rate_generator, one cycle wide.
- i_rx_done  in  1  uart_rx byte-valid pulse, one cycle wide.
- i_rx_data  in  NB_DATA  received byte; valid when i_rx_done=1.
- i_alu_result  in  NB_DATA  combinational ALU output.
- i_tx_done  in  1  uart_tx end-of-frame pulse.
- o_data_a  out  NB_DATA  ALU operand A register.
- o_data_b  out  NB_DATA  ALU operand B register.
- o_op  out  NB_OP  ALU opcode register.
- o_tx_start  out  1  one-cycle start pulse to uart_tx.
- o_tx_data  out  NB_DATA  byte to transmit; held stable from o_tx_start until i_tx_done.
- o_busy  out  1  high in EXEC, SEND and WAIT_TX.
- o_error  out  1  one-cycle pulse on inter-byte timeout.
- o_overrun  out  1  one-cycle pulse when a byte is dropped while busy.

Behaviour:
- Reset (i_reset=0 at a clock edge):
  - State goes to WAIT_A.
  - All output registers clear to 0; timeout counter clears to 0.
  - Reset takes effect in any state, including mid-command and mid-transmit. A uart_tx frame already in progress is not aborted; its i_tx_done is ignored in WAIT_A.
- All outputs are registered. Next-state logic is combinational; the state register is sequential.
- States and transitions (edge n = clock edge where the condition is sampled):
  - WAIT_A: on i_rx_done, o_data_a <= i_rx_data; go to WAIT_B.
  - WAIT_B: on i_rx_done, o_data_b <= i_rx_data; go to WAIT_OP.
  - WAIT_OP: on i_rx_done, o_op <= i_rx_data[NB_OP-1:0]; go to EXEC.
  - EXEC: exactly one cycle; o_tx_data <= i_alu_result; go to SEND.
  - SEND: exactly one cycle; o_tx_start=1; go to WAIT_TX.
  - WAIT_TX: on i_tx_done, go to WAIT_A.
- Latency: i_rx_done of the opcode at edge n gives o_op valid from n+1, o_tx_data valid from n+2, and o_tx_start high during cycle n+2 only.
- Operands and opcode hold their last values until overwritten; they are not cleared on command completion.
- Timeout:
  - Counter active only in WAIT_B and WAIT_OP. It increments on i_tick and clears on i_rx_done or on leaving those states.
  - When the counter would reach TIMEOUT_TICKS: go to WAIT_A, pulse o_error for one cycle, clear the counter.
  - If i_rx_done and the final tick arrive in the same cycle, i_rx_done wins: the byte is accepted and there is no error.
  - Counter width is $clog2(TIMEOUT_TICKS+1); it never wraps.
  - WAIT_A never times out.
- Overrun: i_rx_done in EXEC, SEND or WAIT_TX drops the byte and pulses o_overrun for one cycle; state is unaffected.
- i_tx_done outside WAIT_TX is ignored.
- o_busy = (state ∈ {EXEC, SEND, WAIT_TX}), registered together with the state.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding localparams: WAIT_A=0, WAIT_B=1, WAIT_OP=2, EXEC=3, SEND=4, WAIT_TX=5; 3-bit state;
  - NB_DATA and NB_OP defaults;
  - ALU opcode constants (ADD=6'b100000, SUB=6'b100010, AND=6'b100100, OR=6'b100101, XOR=6'b100110, SRA=6'b000011, SRL=6'b000010, NOR=6'b100111), also used by the bench ALU model.
- Sub-module: inter_byte_timer, the tick counter with clear, enable and expiry pulse.

Test Plan:
- Nominal ADD: rx bytes 0x05, 0x03, 0x20 with the bench ALU model. Expect o_data_a=0x05, o_data_b=0x03, o_op=6'h20; o_tx_data=0x08 with a single o_tx_start pulse 2 cycles after the opcode's i_rx_done. o_busy stays high until i_tx_done, then the state returns to WAIT_A.
- Back-to-back: SUB (0x0A, 0x0C, 0x22) followed immediately by AND (0xF0, 0x3C, 0x24). Expect tx bytes 0xFE then 0x30, exactly 2 o_tx_start pulses, no errors.
- Timeout: send 0x11, then 1600 i_tick pulses with no rx. Expect o_error for one cycle, state back in WAIT_A. Next bytes 0x01, 0x02, 0x20 give tx 0x03.
- Tie at expiry: i_rx_done coincides with the 1600th tick in WAIT_B. Expect o_data_b captured, no o_error, state WAIT_OP.
- Overrun: i_rx_done=1 with data 0x55 during WAIT_TX. Expect a one-cycle o_overrun pulse and registers unchanged; after i_tx_done, the state returns to WAIT_A.
- Reset mid-command: i_reset=0 for one cycle in WAIT_OP. Expect all outputs 0, state WAIT_A, and a following i_tx_done ignored.
